// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned multiply sequenced over four passes of an
// external combinational 4x4 multiplier, with valid/ready on both sides.
module mul8_seq_ctrl #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        busy,
  output logic [1:0]  pass
);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] pp;

  assign pp          = {8'h00, mul_p};
  assign in_ready    = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_product = prod_q;

  // State, latched operands, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Pass sequencing, multiplier operand selection and partial-product accumulation.
  // The result register is separate from acc so the last product survives the
  // accumulator clear on the next accept.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    mul_a   = '0;
    mul_b   = '0;
    pass    = 2'd0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          if ((ZERO_SKIP != 0) && ((in_a == '0) || (in_b == '0))) begin
            prod_d  = '0;
            state_d = DONE;
          end else begin
            state_d = P0;
          end
        end
      end
      P0: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[3:0];
        pass    = 2'd0;
        acc_d   = acc_q + pp;
        state_d = P1;
      end
      P1: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[3:0];
        pass    = 2'd1;
        acc_d   = acc_q + (pp << 4);
        state_d = P2;
      end
      P2: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[7:4];
        pass    = 2'd2;
        acc_d   = acc_q + (pp << 4);
        state_d = P3;
      end
      P3: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[7:4];
        pass    = 2'd3;
        acc_d   = acc_q + (pp << 8);
        prod_d  = acc_d;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks for mul8_seq_ctrl with a behavioural 4x4 multiplier.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b, mul_p;
  logic [3:0]  mul_a, mul_b;
  logic [15:0] out_product;
  logic [1:0]  pass;

  // second instance without zero skipping
  logic        v0, rdy0, ov0, or0, busy0;
  logic [7:0]  a0, b0, mp0;
  logic [3:0]  ma0, mb0;
  logic [15:0] op0;
  logic [1:0]  pass0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};
  assign mp0   = {4'h0, ma0} * {4'h0, mb0};

  mul8_seq_ctrl #(.ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .pass(pass)
  );

  mul8_seq_ctrl #(.ZERO_SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
    .in_a(a0), .in_b(b0), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0),
    .out_valid(ov0), .out_ready(or0), .out_product(op0),
    .busy(busy0), .pass(pass0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands at a negedge, wait (bounded) for in_ready, take the accept edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
  endtask

  task automatic collect(input string tag, input logic [15:0] exp);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_product, exp);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    v0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0;

    // reset values
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // pass sequence for 0x12 * 0x34
    accept(8'h12, 8'h34);
    chk("p0_mul", {mul_a, mul_b}, 8'h24);
    chk("p0_pass", pass, 0);
    chk("p0_busy", busy, 1);
    chk("p0_in_ready", in_ready, 0);
    chk("p0_out_valid", out_valid, 0);
    tick();
    chk("p1_mul", {mul_a, mul_b}, 8'h14);
    chk("p1_pass", pass, 1);
    tick();
    chk("p2_mul", {mul_a, mul_b}, 8'h23);
    chk("p2_pass", pass, 2);
    tick();
    chk("p3_mul", {mul_a, mul_b}, 8'h13);
    chk("p3_pass", pass, 3);
    chk("p3_out_valid", out_valid, 0);
    tick();
    chk("done_out_valid", out_valid, 1);
    chk("done_product", out_product, 16'h03A8);
    chk("done_mul", {mul_a, mul_b}, 8'h00);
    chk("done_pass", pass, 0);

    // backpressure in DONE
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", out_product, 16'h03A8);
      chk("bp_in_ready", in_ready, 0);
    end

    // output handshake with in_valid also high: input must not be taken
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h80; in_b = 8'h02;
    tick();
    out_ready = 1'b0;
    chk("hs_busy", busy, 0);
    chk("hs_out_valid", out_valid, 0);
    chk("hs_product_held", out_product, 16'h03A8);
    chk("hs_in_ready", in_ready, 1);
    accept(8'h80, 8'h02);
    collect("p80x02", 16'h0100);
    accept(8'hFF, 8'hFF);
    collect("pFFxFF", 16'hFE01);

    // zero skip
    accept(8'h00, 8'hAB);
    chk("zs_out_valid", out_valid, 1);
    chk("zs_product", out_product, 16'h0000);
    chk("zs_mul", {mul_a, mul_b}, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("zs_after_hs", out_valid, 0);
    accept(8'h37, 8'h29);
    collect("p37x29", 16'h08CF);
    accept(8'h5C, 8'h00);
    chk("zsb_out_valid", out_valid, 1);
    chk("zsb_product", out_product, 16'h0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // no zero skip: full four passes
    chk("nz_in_ready", rdy0, 1);
    v0 = 1'b1; a0 = 8'h00; b0 = 8'hAB;
    tick();
    v0 = 1'b0; a0 = 8'h55; b0 = 8'h66;
    chk("nz_p0", {ma0, mb0}, 8'h0B);
    chk("nz_p0_valid", ov0, 0);
    tick();
    chk("nz_p1", {ma0, mb0, 2'b00, pass0}, 12'h0B1);
    tick();
    chk("nz_p2", {ma0, mb0, 2'b00, pass0}, 12'h0A2);
    tick();
    chk("nz_p3", {ma0, mb0, 2'b00, pass0}, 12'h0A3);
    chk("nz_p3_valid", ov0, 0);
    tick();
    chk("nz_done_valid", ov0, 1);
    chk("nz_product", op0, 16'h0000);
    or0 = 1'b1;
    tick();
    or0 = 1'b0;
    chk("nz_after_hs", ov0, 0);

    // asynchronous reset during P2
    accept(8'h12, 8'h34);
    tick();
    tick();
    chk("mr_pass_before", pass, 2);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_pass", pass, 0);
    chk("mr_mul", {mul_a, mul_b}, 8'h00);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_product", out_product, 0);
    chk("mr_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("mr_no_result", out_valid, 0);
    chk("mr_idle", busy, 0);
    accept(8'h0F, 8'h0F);
    collect("p0Fx0F", 16'h00E1);

    // random back-to-back traffic through a scoreboard
    fork
      begin : driver
        logic [7:0] ra, rb;
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          ra = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
          rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
          in_valid = 1'b1; in_a = ra; in_b = rb;
          for (int w = 0; w < 200 && !in_ready; w++) tick();
          chk("rnd_accept", in_ready, 1);
          if (!in_ready) break;
          sb.push_back({8'h00, ra} * {8'h00, rb});
          tick();
          in_valid = 1'b0;
        end
      end
      begin : monitor
        int got;
        logic [15:0] e;
        got = 0;
        for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("rnd_unexpected", sb.size(), 1);
            else begin
              e = sb.pop_front();
              chk("rnd_product", out_product, e);
            end
            got++;
          end
          tick();
        end
        out_ready = 1'b0;
        chk("rnd_count", got, 200);
      end
    join
    chk("rnd_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
